dmem_arbiter: RTL and testbench

//   Two-port round-robin arbiter and sequencer for the single-port data_memory.

---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port data_memory.
// One access in flight at a time; every output is registered.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              Mem_read,
  output logic              Mem_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] Read_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;

  state_t            r_state, w_state;
  logic              r_last, w_last;
  logic              r_port, w_port;
  logic              r_we, w_we;
  logic [2:0]        r_cnt, w_cnt;
  logic              r_gnt0, w_gnt0, r_gnt1, w_gnt1;
  logic              r_done0, w_done0, r_done1, w_done1;
  logic              r_mrd, w_mrd, r_mwr, w_mwr;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [DATA_W-1:0] r_rdata0, w_rdata0, r_rdata1, w_rdata1;
  logic              w_sel;
  logic              w_finish;

  always_comb begin
    w_state  = r_state;
    w_last   = r_last;
    w_port   = r_port;
    w_we     = r_we;
    w_cnt    = r_cnt;
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    w_done0  = 1'b0;
    w_done1  = 1'b0;
    w_mrd    = r_mrd;
    w_mwr    = r_mwr;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_rdata0 = r_rdata0;
    w_rdata1 = r_rdata1;
    w_sel    = 1'b0;
    w_finish = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_mrd = 1'b0;
        w_mwr = 1'b0;
        if (req0 || req1) begin
          // On a tie the port that did not win last time goes first.
          w_sel   = (req0 && req1) ? ~r_last : req1;
          w_port  = w_sel;
          w_last  = w_sel;
          w_we    = w_sel ? we1    : we0;
          w_addr  = w_sel ? addr1  : addr0;
          w_wdata = w_sel ? wdata1 : wdata0;
          w_gnt0  = ~w_sel;
          w_gnt1  = w_sel;
          w_mwr   = w_we;
          w_mrd   = ~w_we;
          w_cnt   = 3'(MEM_LAT);
          w_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_mwr = 1'b0;
        if (r_we || MEM_LAT == 0) w_finish = 1'b1;
        else                      w_state  = S_WAIT;
      end
      S_WAIT: begin
        w_cnt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) w_finish = 1'b1;
      end
      default: w_state = S_IDLE;
    endcase

    if (w_finish) begin
      w_state = S_IDLE;
      w_mrd   = 1'b0;
      w_done0 = ~r_port;
      w_done1 = r_port;
      if (!r_we) begin
        if (r_port) w_rdata1 = Read_data;
        else        w_rdata0 = Read_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_port   <= 1'b0;
      r_we     <= 1'b0;
      r_cnt    <= '0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_mrd    <= 1'b0;
      r_mwr    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state  <= w_state;
      r_last   <= w_last;
      r_port   <= w_port;
      r_we     <= w_we;
      r_cnt    <= w_cnt;
      r_gnt0   <= w_gnt0;
      r_gnt1   <= w_gnt1;
      r_done0  <= w_done0;
      r_done1  <= w_done1;
      r_mrd    <= w_mrd;
      r_mwr    <= w_mwr;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_rdata0 <= w_rdata0;
      r_rdata1 <= w_rdata1;
    end
  end

  assign gnt0       = r_gnt0;
  assign gnt1       = r_gnt1;
  assign done0      = r_done0;
  assign done1      = r_done1;
  assign rdata0     = r_rdata0;
  assign rdata1     = r_rdata1;
  assign Mem_read   = r_mrd;
  assign Mem_write  = r_mwr;
  assign addr       = r_addr;
  assign write_data = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (MEM_LAT 1, 0, 3), each with a small
// latency-accurate memory; read results are checked through a scoreboard queue.
module tb_dmem_arbiter;

  localparam int NI = 3;

  typedef struct {
    int          k;
    int          p;
    bit          we;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    int          k;
    int          p;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req   [NI][2];
  logic        we    [NI][2];
  logic [31:0] ain   [NI][2];
  logic [31:0] din   [NI][2];
  logic        gnt   [NI][2];
  logic        done  [NI][2];
  logic [31:0] rdata [NI][2];
  logic        mrd   [NI];
  logic        mwr   [NI];
  logic [31:0] maddr [NI];
  logic [31:0] mwdat [NI];
  logic [31:0] rd    [NI];

  logic [31:0] model  [NI][16];
  logic [31:0] exp_rd [NI][2];
  sb_t         sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int k, input int i);
    return 32'h1000_0000 + 32'(k * 256 + i);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g
    localparam int L = (k == 0) ? 1 : (k == 1) ? 0 : 3;
    logic [31:0] mem [16];
    int unsigned age = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) u_dut (
      .clk(clk), .reset(reset),
      .req0(req[k][0]), .req1(req[k][1]), .we0(we[k][0]), .we1(we[k][1]),
      .addr0(ain[k][0]), .addr1(ain[k][1]), .wdata0(din[k][0]), .wdata1(din[k][1]),
      .gnt0(gnt[k][0]), .gnt1(gnt[k][1]), .done0(done[k][0]), .done1(done[k][1]),
      .rdata0(rdata[k][0]), .rdata1(rdata[k][1]),
      .Mem_read(mrd[k]), .Mem_write(mwr[k]), .addr(maddr[k]), .write_data(mwdat[k]),
      .Read_data(rd[k])
    );

    initial for (int i = 0; i < 16; i++) mem[i] = init_val(k, i);

    // Data is only valid once Mem_read has been held for L cycles.
    always @(posedge clk) begin
      if (mwr[k]) mem[maddr[k][3:0]] <= mwdat[k];
      age <= mrd[k] ? age + 1 : 0;
    end
    assign rd[k] = (mrd[k] && age >= L) ? mem[maddr[k][3:0]] : 32'hBAD0_BAD0;
  end

  always @(negedge clk) begin
    sb_t e;
    for (int k = 0; k < NI; k++) begin
      chk("rd_wr_exclusive", 32'(mrd[k] & mwr[k]), 32'd0);
      for (int p = 0; p < 2; p++) begin
        if (done[k][p]) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done inst %0d port %0d @%0t", k, p, $time);
          end else begin
            e = sbq.pop_front();
            chk("done_inst", 32'(k), 32'(e.k));
            chk("done_port", 32'(p), 32'(e.p));
            if (!e.we) begin
              chk("rdata", rdata[k][p], e.data);
              exp_rd[k][p] = e.data;
            end
          end
        end
      end
    end
  end

  task automatic access(input int k, input int p, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int exp_cyc);
    int  cyc = 0;
    bit  got_done = 1'b0;
    int  q = 1 - p;
    sb_t e;
    we[k][p]  = w;
    ain[k][p] = a;
    din[k][p] = d;
    req[k][p] = 1'b1;
    e.k = k; e.p = p; e.we = w; e.data = model[k][a[3:0]];
    if (w) model[k][a[3:0]] = d;
    sbq.push_back(e);
    while (!got_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      chk("gnt_other", 32'(gnt[k][q]), 32'd0);
      chk("gnt_cycle", 32'(gnt[k][p]), 32'(cyc == 1));
      if (gnt[k][p]) req[k][p] = 1'b0;
      if (done[k][p]) begin
        got_done = 1'b1;
        chk("done_cycle", 32'(cyc), 32'(exp_cyc));
        chk("mem_idle_at_done", 32'(mrd[k] | mwr[k]), 32'd0);
      end else if (w) begin
        chk("mem_write", 32'(mwr[k]), 32'(cyc == 1));
        if (cyc == 1) begin
          chk("wr_addr", maddr[k], a);
          chk("wr_data", mwdat[k], d);
        end
      end else begin
        chk("mem_read", 32'(mrd[k]), 32'd1);
        chk("rd_addr", maddr[k], a);
      end
    end
    if (!got_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout inst %0d port %0d: no done within 20 cycles", k, p);
      req[k][p] = 1'b0;
    end
    chk("rdata_other_kept", rdata[k][q], exp_rd[k][q]);
    if (w) chk("rdata_kept_on_write", rdata[k][p], exp_rd[k][p]);
  endtask

  vec_t tbl [11];
  int   order [4];
  int   ng;
  int   cyc;

  initial begin
    tbl[0]  = '{0, 0, 1'b1, 32'd2,  32'h0000_000C, 2};
    tbl[1]  = '{0, 0, 1'b0, 32'd2,  32'h0,         3};
    tbl[2]  = '{0, 1, 1'b1, 32'd7,  32'hA5A5_0001, 2};
    tbl[3]  = '{0, 1, 1'b0, 32'd7,  32'h0,         3};
    tbl[4]  = '{0, 0, 1'b0, 32'd3,  32'h0,         3};
    tbl[5]  = '{1, 0, 1'b1, 32'd1,  32'h1111_2222, 2};
    tbl[6]  = '{1, 0, 1'b0, 32'd1,  32'h0,         2};
    tbl[7]  = '{1, 1, 1'b0, 32'd9,  32'h0,         2};
    tbl[8]  = '{2, 1, 1'b1, 32'd4,  32'hCAFE_F00D, 2};
    tbl[9]  = '{2, 0, 1'b0, 32'd4,  32'h0,         5};
    tbl[10] = '{2, 1, 1'b0, 32'd15, 32'h0,         5};

    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 16; i++) model[k][i] = init_val(k, i);
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 1'b0; we[k][p] = 1'b0; ain[k][p] = '0; din[k][p] = '0;
        exp_rd[k][p] = '0;
      end
    end

    // Reset held with a pending port-0 request: nothing may move.
    we[0][0] = 1'b1; ain[0][0] = 32'd2; din[0][0] = 32'h0000_000C; req[0][0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt0", 32'(gnt[0][0]), 32'd0);
    chk("rst_gnt1", 32'(gnt[0][1]), 32'd0);
    chk("rst_done0", 32'(done[0][0]), 32'd0);
    chk("rst_mem_rw", 32'({mrd[0], mwr[0]}), 32'd0);
    chk("rst_addr", maddr[0], 32'd0);
    chk("rst_wdata", mwdat[0], 32'd0);
    chk("rst_rdata0", rdata[0][0], 32'd0);
    chk("rst_rdata1", rdata[0][1], 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++)
      access(tbl[i].k, tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].cyc);

    // Reset during the WAIT phase of a port-1 read on the MEM_LAT=3 instance.
    we[2][1] = 1'b0; ain[2][1] = 32'd6; req[2][1] = 1'b1;
    @(negedge clk);
    chk("abort_gnt1", 32'(gnt[2][1]), 32'd1);
    @(negedge clk);
    chk("abort_in_wait", 32'(mrd[2]), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_mem_read", 32'(mrd[2]), 32'd0);
    chk("abort_addr", maddr[2], 32'd0);
    chk("abort_rdata0_inst0", rdata[0][0], 32'd0);
    for (int k = 0; k < NI; k++) for (int p = 0; p < 2; p++) exp_rd[k][p] = '0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done1", 32'(done[2][1]), 32'd0);
    end
    reset = 1'b1;
    access(2, 1, 1'b0, 32'd6, 32'h0, 5);

    // Both ports held continuously on instance 0 (pointer fresh from reset).
    we[0][0] = 1'b0; ain[0][0] = 32'd4;
    we[0][1] = 1'b0; ain[0][1] = 32'd5;
    for (int i = 0; i < 4; i++) begin
      sb_t e;
      e.k = 0; e.p = i % 2; e.we = 1'b0; e.data = model[0][(i % 2) ? 5 : 4];
      sbq.push_back(e);
    end
    req[0][0] = 1'b1; req[0][1] = 1'b1;
    ng = 0; cyc = 0;
    while (ng < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (gnt[0][p]) begin
          if (ng < 4) order[ng] = p;
          ng++;
        end
      end
      if (ng >= 4) begin
        req[0][0] = 1'b0; req[0][1] = 1'b0;
      end
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    chk("rr_grant_count", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < ng) chk("rr_order", 32'(order[i]), 32'(i % 2));
    while (sbq.size() != 0 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
